// File: rtl/shader_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shader_program_sequencer
// Description : Owns the shader instruction memory write port. SPI writes are
//               passed straight through; every frames_per_prog_i frames, during
//               vertical blanking, the next preset program is streamed from a
//               synchronous (1-cycle latency) ROM into shader memory. Any SPI
//               strobe or loss of blanking aborts a stream in progress.
// Ports       : clk_i/rst_ni        - pixel clock, async active-low reset
//               next_frame_i        - pulse at start of vertical blanking
//               vblank_i            - high during vertical blanking
//               auto_enable_i       - enables the automatic player
//               frames_per_prog_i   - frames between switches (0 = never)
//               spi_instr/load/shift_i - SPI receiver write port
//               rom_addr_o/rom_data_i  - program ROM, address = {prog, index}
//               mem_instr/load/shift_o - shader memory write port
//               prog_idx_o          - program currently resident
//               busy_o              - streaming (PRIME or STREAM)
//               manual_o            - sticky SPI-activity flag
//               load_done_o         - pulse after a complete stream
// Revision    : 1.0 - initial release
// ============================================================================
module shader_program_sequencer #(
    parameter int NUM_PROGS = 4,
    parameter int PROG_LEN  = 32,
    parameter int ROM_AW    = $clog2(NUM_PROGS * PROG_LEN)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         next_frame_i,
    input  logic                         vblank_i,
    input  logic                         auto_enable_i,
    input  logic [7:0]                   frames_per_prog_i,
    input  logic [7:0]                   spi_instr_i,
    input  logic                         spi_load_i,
    input  logic                         spi_shift_i,
    output logic [ROM_AW-1:0]            rom_addr_o,
    input  logic [7:0]                   rom_data_i,
    output logic [7:0]                   mem_instr_o,
    output logic                         mem_load_o,
    output logic                         mem_shift_o,
    output logic [$clog2(NUM_PROGS)-1:0] prog_idx_o,
    output logic                         busy_o,
    output logic                         manual_o,
    output logic                         load_done_o
);

    localparam int c_PROG_W = $clog2(NUM_PROGS);
    localparam int c_IDX_W  = $clog2(PROG_LEN);
    localparam logic [c_IDX_W-1:0] c_LAST_BEAT = c_IDX_W'(PROG_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t                state_q,  state_d;
    logic [7:0]            fcnt_q,   fcnt_d;
    logic [c_PROG_W-1:0]   prog_q,   prog_d;
    logic [c_PROG_W-1:0]   target_q, target_d;
    logic [c_IDX_W-1:0]    beat_q,   beat_d;
    logic                  manual_q, manual_d;
    logic                  done_q,   done_d;

    logic w_spi_any;
    logic w_count_en;
    logic w_fcnt_hit;
    logic w_trigger;
    logic w_abort;

    // ------------------------------------------------------------------
    // Frame counter, trigger and manual flag
    // ------------------------------------------------------------------
    always_comb begin
        w_spi_any  = spi_load_i | spi_shift_i;
        w_count_en = auto_enable_i & ~manual_q;
        w_fcnt_hit = next_frame_i && (frames_per_prog_i != 8'd0)
                     && (fcnt_q == frames_per_prog_i - 8'd1);
        // An SPI strobe in the trigger cycle wins: the frame is consumed but
        // no stream is started.
        w_trigger  = w_fcnt_hit && w_count_en && !w_spi_any;

        fcnt_d = fcnt_q;
        if (!w_count_en) begin
            fcnt_d = 8'd0;
        end else if (next_frame_i) begin
            fcnt_d = w_fcnt_hit ? 8'd0 : fcnt_q + 8'd1;
        end

        // Setting takes precedence over the clear by auto_enable_i low.
        manual_d = manual_q;
        if (w_spi_any) begin
            manual_d = 1'b1;
        end else if (!auto_enable_i) begin
            manual_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stream FSM and write-port mux
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        beat_d      = beat_q;
        prog_d      = prog_q;
        done_d      = 1'b0;
        rom_addr_o  = '0;
        mem_instr_o = spi_instr_i;
        mem_load_o  = spi_load_i;
        mem_shift_o = spi_shift_i;
        w_abort     = w_spi_any | ~vblank_i;

        case (state_q)
            ST_IDLE: begin
                // A trigger outside blanking is silently dropped.
                if (w_trigger && vblank_i) begin
                    target_d = prog_q + 1'b1;
                    state_d  = ST_PRIME;
                end
            end
            ST_PRIME: begin
                rom_addr_o = {target_q, {c_IDX_W{1'b0}}};
                beat_d     = '0;
                state_d    = w_abort ? ST_IDLE : ST_STREAM;
            end
            ST_STREAM: begin
                // Address runs one ahead of the beat to cover ROM latency.
                rom_addr_o = {target_q, c_IDX_W'(beat_q + 1'b1)};
                if (w_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_instr_o = rom_data_i;
                    mem_load_o  = 1'b1;
                    mem_shift_o = 1'b1;
                    if (beat_q == c_LAST_BEAT) begin
                        state_d = ST_IDLE;
                        prog_d  = target_q;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            fcnt_q   <= 8'd0;
            prog_q   <= '0;
            target_q <= '0;
            beat_q   <= '0;
            manual_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            prog_q   <= prog_d;
            target_q <= target_d;
            beat_q   <= beat_d;
            manual_q <= manual_d;
            done_q   <= done_d;
        end
    end

    assign prog_idx_o  = prog_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign manual_o    = manual_q;
    assign load_done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shader_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shader_program_sequencer
// Description : Self-checking bench for shader_program_sequencer. A cycle-
//               position model (cycles since trigger, resident program, frame
//               count, manual flag) predicts every output each cycle; directed
//               scenarios add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shader_program_sequencer;

    localparam int NP  = 4;
    localparam int PL  = 32;
    localparam int AW  = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            next_frame, vblank, auto_en;
    logic [7:0]      fpp;
    logic [7:0]      spi_instr;
    logic            spi_load, spi_shift;
    logic [AW-1:0]   rom_addr;
    logic [7:0]      rom_data = 8'd0;
    logic [7:0]      mem_instr;
    logic            mem_load, mem_shift;
    logic [1:0]      prog_idx;
    logic            busy, manual, load_done;

    shader_program_sequencer #(.NUM_PROGS(NP), .PROG_LEN(PL), .ROM_AW(AW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .next_frame_i     (next_frame),
        .vblank_i         (vblank),
        .auto_enable_i    (auto_en),
        .frames_per_prog_i(fpp),
        .spi_instr_i      (spi_instr),
        .spi_load_i       (spi_load),
        .spi_shift_i      (spi_shift),
        .rom_addr_o       (rom_addr),
        .rom_data_i       (rom_data),
        .mem_instr_o      (mem_instr),
        .mem_load_o       (mem_load),
        .mem_shift_o      (mem_shift),
        .prog_idx_o       (prog_idx),
        .busy_o           (busy),
        .manual_o         (manual),
        .load_done_o      (load_done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: each word holds its own address.
    always @(posedge clk) rom_data <= {1'b0, rom_addr};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Behavioural model. m_pos = cycles since the trigger was sampled
    // (0 = not streaming, 1 = address priming, 2..PL+1 = beats).
    // ---------------------------------------------------------------
    int   m_pos = 0, m_prog = 0, m_target = 0, m_fcnt = 0;
    bit   m_manual = 0, m_done = 0;
    bit   m_spi, m_hit, m_trig, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_prog = 0; m_target = 0; m_fcnt = 0; m_manual = 0; m_done = 0;
        end else begin
            m_spi  = spi_load | spi_shift;
            m_cnt  = auto_en && !m_manual;
            m_hit  = next_frame && (fpp != 0) && (m_fcnt == int'(fpp) - 1);
            m_trig = m_hit && m_cnt && !m_spi;
            m_done = 0;
            if (m_pos != 0) begin
                if (m_spi || !vblank) m_pos = 0;
                else if (m_pos == PL + 1) begin
                    m_pos = 0; m_prog = m_target; m_done = 1;
                end else m_pos++;
            end else if (m_trig && vblank) begin
                m_target = (m_prog + 1) % NP;
                m_pos = 1;
            end
            if (!m_cnt) m_fcnt = 0;
            else if (next_frame) m_fcnt = m_hit ? 0 : (m_fcnt + 1) % 256;
            if (m_spi) m_manual = 1;
            else if (!auto_en) m_manual = 0;
        end
    end

    int e_instr;
    bit e_beat;
    always @(negedge clk) begin
        if (rst_n) begin
            e_beat = (m_pos >= 2) && !(spi_load || spi_shift) && vblank;
            chk("busy", busy, m_pos != 0);
            chk("prog_idx", prog_idx, m_prog);
            chk("manual", manual, m_manual);
            chk("load_done", load_done, m_done);
            if (m_pos == 0) chk("rom_addr_idle", rom_addr, 0);
            else if (m_pos <= PL) chk("rom_addr", rom_addr, m_target * PL + m_pos - 1);
            if (e_beat) begin
                e_instr = (m_target * PL + m_pos - 2) % 256;
                chk("beat_load", mem_load, 1);
                chk("beat_shift", mem_shift, 1);
                chk("beat_instr", mem_instr, e_instr);
            end else begin
                chk("pass_load", mem_load, spi_load);
                chk("pass_shift", mem_shift, spi_shift);
                if (spi_load || spi_shift) chk("pass_instr", mem_instr, spi_instr);
            end
        end
    end

    // Counts ROM beats seen on the memory port (strobes not caused by SPI).
    int beat_cnt = 0;
    always @(negedge clk) if (rst_n && mem_load && !spi_load && !spi_shift) beat_cnt++;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_frame(input logic vb);
        vblank = vb; next_frame = 1'b1; tick(); next_frame = 1'b0;
    endtask

    task automatic end_frame();
        repeat (40) tick();
        vblank = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b1; next_frame = 0; vblank = 0; auto_en = 0; fpp = 0;
        spi_instr = 0; spi_load = 0; spi_shift = 0;

        // Reset state and combinational pass-through during reset
        #2 rst_n = 1'b0;
        #1 spi_instr = 8'hA5; spi_load = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_manual", manual, 0);
        chk("rst_prog", prog_idx, 0);
        chk("rst_done", load_done, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_pass_load", mem_load, 1);
        chk("rst_pass_shift", mem_shift, 0);
        chk("rst_pass_instr", mem_instr, 8'hA5);
        spi_load = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Full stream: program 1, data 32..63 on cycles 2..33
        auto_en = 1'b1; fpp = 8'd1; tick();
        start_frame(1'b1);
        @(negedge clk); chk("fs_c1_busy", busy, 1); chk("fs_c1_addr", rom_addr, 32);
        tick(); @(negedge clk); chk("fs_c2_instr", mem_instr, 32); chk("fs_c2_load", mem_load, 1);
        repeat (31) tick(); @(negedge clk); chk("fs_c33_instr", mem_instr, 63);
        tick(); @(negedge clk);
        chk("fs_c34_done", load_done, 1); chk("fs_c34_prog", prog_idx, 1); chk("fs_c34_busy", busy, 0);
        end_frame();

        // Wrap: programs 2, 3, then 0 read from addresses 0..31
        for (int i = 2; i <= 4; i++) begin
            start_frame(1'b1);
            if (i == 4) begin
                tick(); @(negedge clk); chk("wrap_first", mem_instr, 0);
                repeat (31) tick(); @(negedge clk); chk("wrap_last", mem_instr, 31);
            end
            end_frame();
            chk("wrap_prog", prog_idx, i % NP);
        end

        // SPI preemption at beat 10
        beat_cnt = 0;
        start_frame(1'b1);
        repeat (11) tick();
        spi_instr = 8'h5A; spi_shift = 1'b1;
        @(negedge clk);
        chk("pre_instr", mem_instr, 8'h5A); chk("pre_shift", mem_shift, 1); chk("pre_load", mem_load, 0);
        tick(); spi_shift = 1'b0;
        @(negedge clk); chk("pre_busy_next", busy, 0);
        chk("pre_beats", beat_cnt, 10);
        end_frame();
        chk("pre_prog", prog_idx, 0); chk("pre_manual", manual, 1);
        start_frame(1'b1); @(negedge clk); chk("manual_blocks", busy, 0); end_frame();
        auto_en = 1'b0; tick(); auto_en = 1'b1; tick();
        chk("manual_clr", manual, 0);

        // Blanking abort at beat 5, retry after frames_per_prog frames
        fpp = 8'd2;
        start_frame(1'b1); end_frame();
        start_frame(1'b1);
        repeat (6) tick();
        vblank = 1'b0;
        @(negedge clk); chk("vb_drop_load", mem_load, 0);
        tick(); @(negedge clk); chk("vb_busy_next", busy, 0);
        end_frame();
        start_frame(1'b1); @(negedge clk); chk("vb_no_early", busy, 0); end_frame();
        start_frame(1'b1);
        repeat (33) tick(); @(negedge clk);
        chk("vb_retry_done", load_done, 1); chk("vb_retry_prog", prog_idx, 1);
        end_frame();

        // Counter: every third frame, then never with 0
        fpp = 8'd3;
        for (int f = 0; f < 6; f++) begin
            start_frame(1'b1); @(negedge clk);
            chk("cnt3_trig", busy, (f % 3) == 2);
            end_frame();
        end
        chk("cnt3_prog", prog_idx, 3);
        fpp = 8'd0;
        for (int f = 0; f < 10; f++) begin
            start_frame(1'b1); @(negedge clk); chk("cnt0_none", busy, 0); end_frame();
        end

        // Late trigger outside blanking is ignored
        auto_en = 1'b0; tick(); auto_en = 1'b1; fpp = 8'd1; tick();
        start_frame(1'b0); @(negedge clk); chk("late_ignored", busy, 0); end_frame();

        // Asynchronous reset mid-stream
        start_frame(1'b1);
        repeat (9) tick();
        #1 rst_n = 1'b0;
        #1 spi_instr = 8'h33; spi_load = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_addr", rom_addr, 0);
        chk("arst_prog", prog_idx, 0);
        chk("arst_done", load_done, 0);
        chk("arst_manual", manual, 0);
        chk("arst_load", mem_load, 1);
        chk("arst_shift", mem_shift, 0);
        chk("arst_instr", mem_instr, 8'h33);
        spi_load = 1'b0; vblank = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
